register_block: RTL and testbench



---
 rtl/register_block.sv | 127 ++++++++++++
 tb/tb_register_block.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_block.sv
// ----------------------------------------------------------------------------
// register_block
//   Warp-banked, per-lane register file with two combinational read ports and
//   one write port. Storage is mem[warp][lane][reg], DATA_W bits per entry.
//
//   Ports
//     clk, rst_n               single clock, asynchronous active-low reset
//     warp_selector            warp context for all reads and writes
//     read_en_0/1, raddr_0/1   per-lane read enables and shared read addresses
//     write_en, waddr          per-lane write enables and shared write address
//     wdata_0 .. wdata_15      per-lane write data
//     rdata_0_<l>, rdata_1_<l> per-lane read data, port 0 / port 1
//
//   Configuration
//     REGISTER_BLOCK_BYPASS_EN  when defined, a read that hits the address
//                               being written in the same cycle returns the
//                               incoming write data instead of the stored
//                               value.
// ----------------------------------------------------------------------------
module register_block #(
    parameter int NUM_LANES = 16,
    parameter int NUM_WARPS = 16,
    parameter int NUM_REGS  = 16,
    parameter int DATA_W    = 64,
    localparam int WARP_W   = $clog2(NUM_WARPS),
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WARP_W-1:0]    warp_selector,
    input  logic [NUM_LANES-1:0] read_en_0,
    input  logic [NUM_LANES-1:0] read_en_1,
    input  logic [REG_W-1:0]     raddr_0,
    input  logic [REG_W-1:0]     raddr_1,
    input  logic [NUM_LANES-1:0] write_en,
    input  logic [REG_W-1:0]     waddr,
    input  logic [DATA_W-1:0]    wdata_0,  wdata_1,  wdata_2,  wdata_3,
    input  logic [DATA_W-1:0]    wdata_4,  wdata_5,  wdata_6,  wdata_7,
    input  logic [DATA_W-1:0]    wdata_8,  wdata_9,  wdata_10, wdata_11,
    input  logic [DATA_W-1:0]    wdata_12, wdata_13, wdata_14, wdata_15,
    output logic [DATA_W-1:0]    rdata_0_0,  rdata_0_1,  rdata_0_2,  rdata_0_3,
    output logic [DATA_W-1:0]    rdata_0_4,  rdata_0_5,  rdata_0_6,  rdata_0_7,
    output logic [DATA_W-1:0]    rdata_0_8,  rdata_0_9,  rdata_0_10, rdata_0_11,
    output logic [DATA_W-1:0]    rdata_0_12, rdata_0_13, rdata_0_14, rdata_0_15,
    output logic [DATA_W-1:0]    rdata_1_0,  rdata_1_1,  rdata_1_2,  rdata_1_3,
    output logic [DATA_W-1:0]    rdata_1_4,  rdata_1_5,  rdata_1_6,  rdata_1_7,
    output logic [DATA_W-1:0]    rdata_1_8,  rdata_1_9,  rdata_1_10, rdata_1_11,
    output logic [DATA_W-1:0]    rdata_1_12, rdata_1_13, rdata_1_14, rdata_1_15
);

    // Lane-indexed views of the enumerated per-lane ports.
    logic [NUM_LANES-1:0][DATA_W-1:0] wdata_a;
    logic [NUM_LANES-1:0][DATA_W-1:0] rdata0_a;
    logic [NUM_LANES-1:0][DATA_W-1:0] rdata1_a;

    assign wdata_a = {wdata_15, wdata_14, wdata_13, wdata_12,
                      wdata_11, wdata_10, wdata_9,  wdata_8,
                      wdata_7,  wdata_6,  wdata_5,  wdata_4,
                      wdata_3,  wdata_2,  wdata_1,  wdata_0};

    assign {rdata_0_15, rdata_0_14, rdata_0_13, rdata_0_12,
            rdata_0_11, rdata_0_10, rdata_0_9,  rdata_0_8,
            rdata_0_7,  rdata_0_6,  rdata_0_5,  rdata_0_4,
            rdata_0_3,  rdata_0_2,  rdata_0_1,  rdata_0_0} = rdata0_a;

    assign {rdata_1_15, rdata_1_14, rdata_1_13, rdata_1_12,
            rdata_1_11, rdata_1_10, rdata_1_9,  rdata_1_8,
            rdata_1_7,  rdata_1_6,  rdata_1_5,  rdata_1_4,
            rdata_1_3,  rdata_1_2,  rdata_1_1,  rdata_1_0} = rdata1_a;

    // Each lane owns an independent bank; lanes never see each other's data.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [DATA_W-1:0] mem_q [NUM_WARPS][NUM_REGS];
        logic [DATA_W-1:0] mem_d [NUM_WARPS][NUM_REGS];
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;

        always_comb begin
            mem_d = mem_q;
            if (write_en[l]) begin
                mem_d[warp_selector][waddr] = wdata_a[l];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int w = 0; w < NUM_WARPS; w++) begin
                    for (int r = 0; r < NUM_REGS; r++) begin
                        mem_q[w][r] <= '0;
                    end
                end
            end else begin
                mem_q <= mem_d;
            end
        end

        // Outputs are forced to zero during reset so nothing leaks out while
        // the asynchronous clear is in progress.
        always_comb begin
            rd0 = '0;
            if (rst_n && read_en_0[l]) begin
                rd0 = mem_q[warp_selector][raddr_0];
`ifdef REGISTER_BLOCK_BYPASS_EN
                if (write_en[l] && (raddr_0 == waddr)) begin
                    rd0 = wdata_a[l];
                end
`endif
            end
        end

        always_comb begin
            rd1 = '0;
            if (rst_n && read_en_1[l]) begin
                rd1 = mem_q[warp_selector][raddr_1];
`ifdef REGISTER_BLOCK_BYPASS_EN
                if (write_en[l] && (raddr_1 == waddr)) begin
                    rd1 = wdata_a[l];
                end
`endif
            end
        end

        assign rdata0_a[l] = rd0;
        assign rdata1_a[l] = rd1;
    end

endmodule

// File: tb/tb_register_block.sv
module tb_register_block;

    logic        clk;
    logic        rst_n;
    logic [3:0]  warp_selector;
    logic [15:0] read_en_0, read_en_1;
    logic [3:0]  raddr_0, raddr_1;
    logic [15:0] write_en;
    logic [3:0]  waddr;
    logic [63:0] wd  [16];
    logic [63:0] rd0 [16];
    logic [63:0] rd1 [16];

    typedef struct {
        bit          port;
        int          lane;
        logic [63:0] exp;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [63:0] model [16][16][16];
    int          tests_run;
    int          tests_failed;

    register_block dut (
        .clk(clk), .rst_n(rst_n), .warp_selector(warp_selector),
        .read_en_0(read_en_0), .read_en_1(read_en_1),
        .raddr_0(raddr_0), .raddr_1(raddr_1),
        .write_en(write_en), .waddr(waddr),
        .wdata_0(wd[0]),   .wdata_1(wd[1]),   .wdata_2(wd[2]),   .wdata_3(wd[3]),
        .wdata_4(wd[4]),   .wdata_5(wd[5]),   .wdata_6(wd[6]),   .wdata_7(wd[7]),
        .wdata_8(wd[8]),   .wdata_9(wd[9]),   .wdata_10(wd[10]), .wdata_11(wd[11]),
        .wdata_12(wd[12]), .wdata_13(wd[13]), .wdata_14(wd[14]), .wdata_15(wd[15]),
        .rdata_0_0(rd0[0]),   .rdata_0_1(rd0[1]),   .rdata_0_2(rd0[2]),   .rdata_0_3(rd0[3]),
        .rdata_0_4(rd0[4]),   .rdata_0_5(rd0[5]),   .rdata_0_6(rd0[6]),   .rdata_0_7(rd0[7]),
        .rdata_0_8(rd0[8]),   .rdata_0_9(rd0[9]),   .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
        .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
        .rdata_1_0(rd1[0]),   .rdata_1_1(rd1[1]),   .rdata_1_2(rd1[2]),   .rdata_1_3(rd1[3]),
        .rdata_1_4(rd1[4]),   .rdata_1_5(rd1[5]),   .rdata_1_6(rd1[6]),   .rdata_1_7(rd1[7]),
        .rdata_1_8(rd1[8]),   .rdata_1_9(rd1[9]),   .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
        .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one write; the model updates only when the DUT samples it.
    task automatic do_write(input logic [3:0] w, input logic [3:0] a,
                            input logic [15:0] m, input logic [63:0] d [16]);
        warp_selector = w;
        waddr         = a;
        write_en      = m;
        for (int l = 0; l < 16; l++) wd[l] = d[l];
        @(posedge clk);
        if (rst_n) begin
            for (int l = 0; l < 16; l++) if (m[l]) model[w][l][a] = d[l];
        end
        #1;
        write_en = '0;
    endtask

    // Apply read stimulus and push the model's expected outputs.
    task automatic push_reads(input logic [3:0] w, input logic [3:0] a0, input logic [3:0] a1,
                              input logic [15:0] e0, input logic [15:0] e1);
        sb_entry_t e;
        warp_selector = w;
        raddr_0       = a0;
        raddr_1       = a1;
        read_en_0     = e0;
        read_en_1     = e1;
        for (int l = 0; l < 16; l++) begin
            e.lane = l;
            e.port = 1'b0;
            e.exp  = (rst_n && e0[l]) ? model[w][l][a0] : 64'h0;
            sb.push_back(e);
            e.port = 1'b1;
            e.exp  = (rst_n && e1[l]) ? model[w][l][a1] : 64'h0;
            sb.push_back(e);
        end
    endtask

    task automatic clear_model();
        for (int w = 0; w < 16; w++)
            for (int l = 0; l < 16; l++)
                for (int r = 0; r < 16; r++) model[w][l][r] = 64'h0;
    endtask

    task automatic test_reset();
        sb_entry_t   e;
        logic [63:0] act;
        logic [63:0] d [16];
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        // Writes presented while in reset must be ignored.
        for (int l = 0; l < 16; l++) d[l] = 64'hDEAD_0000 + 64'(l);
        do_write(4'd3, 4'd4, 16'hFFFF, d);
        push_reads(4'd3, 4'd4, 4'd4, 16'hFFFF, 16'hFFFF);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL reset_hold port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
        // Release mid-cycle; the very next edge must accept a write.
        rst_n = 1'b1;
        for (int l = 0; l < 16; l++) d[l] = 64'hC0DE_0000 + 64'(l);
        do_write(4'd3, 4'd4, 16'hFFFF, d);
        push_reads(4'd3, 4'd4, 4'd4, 16'hFFFF, 16'hFFFF);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL first_write port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
        // Asynchronous clear without any clock edge, then full readback.
        #1 rst_n = 1'b0;
        clear_model();
        #1 rst_n = 1'b1;
        for (int w = 0; w < 16; w++) begin
            for (int r = 0; r < 16; r++) begin
                push_reads(4'(w), 4'(r), 4'(r), 16'hFFFF, 16'hFFFF);
                #1;
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    act = e.port ? rd1[e.lane] : rd0[e.lane];
                    tests_run++;
                    if (act !== e.exp) begin
                        tests_failed++;
                        $display("FAIL reset_clear w%0d r%0d port%0d lane%0d got %h want %h",
                                 w, r, e.port, e.lane, act, e.exp);
                    end
                end
            end
        end
    endtask

    task automatic test_sweep();
        sb_entry_t   e;
        logic [63:0] act;
        logic [63:0] d [16];
        for (int w = 0; w < 16; w++) begin
            for (int r = 0; r < 16; r++) begin
                for (int l = 0; l < 16; l++) d[l] = {$urandom, $urandom};
                do_write(4'(w), 4'(r), 16'hFFFF, d);
            end
        end
        for (int w = 0; w < 16; w++) begin
            for (int r = 0; r < 16; r++) begin
                for (int mode = 0; mode < 3; mode++) begin
                    case (mode)
                        0:       push_reads(4'(w), 4'(r), 4'(r), 16'hFFFF, 16'h0000);
                        1:       push_reads(4'(w), 4'(r), 4'(r), 16'h0000, 16'hFFFF);
                        default: push_reads(4'(w), 4'(r), 4'(r ^ 5), 16'hFFFF, 16'hFFFF);
                    endcase
                    #1;
                    while (sb.size() > 0) begin
                        e = sb.pop_front();
                        act = e.port ? rd1[e.lane] : rd0[e.lane];
                        tests_run++;
                        if (act !== e.exp) begin
                            tests_failed++;
                            $display("FAIL sweep w%0d r%0d mode%0d port%0d lane%0d got %h want %h",
                                     w, r, mode, e.port, e.lane, act, e.exp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_lane_mask();
        sb_entry_t   e;
        logic [63:0] act;
        logic [63:0] d [16];
        for (int l = 0; l < 16; l++) d[l] = 64'h1;
        do_write(4'd2, 4'd3, 16'hFFFF, d);
        for (int l = 0; l < 16; l++) d[l] = 64'hA5A5;
        do_write(4'd2, 4'd3, 16'h0001, d);
        push_reads(4'd2, 4'd3, 4'd3, 16'hFFFF, 16'hFFFF);
        sb.delete();
        for (int l = 0; l < 16; l++) begin
            e.lane = l;
            e.exp  = (l == 0) ? 64'hA5A5 : 64'h1;
            e.port = 1'b0; sb.push_back(e);
            e.port = 1'b1; sb.push_back(e);
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL lane_mask port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
    endtask

    task automatic test_warp_isolation();
        sb_entry_t   e;
        logic [63:0] act;
        logic [63:0] d [16];
        for (int l = 0; l < 16; l++) d[l] = 64'h1111;
        do_write(4'd0, 4'd5, 16'hFFFF, d);
        for (int l = 0; l < 16; l++) d[l] = 64'h2222;
        do_write(4'd1, 4'd5, 16'hFFFF, d);
        for (int w = 0; w < 2; w++) begin
            push_reads(4'(w), 4'd5, 4'd5, 16'hFFFF, 16'hFFFF);
            sb.delete();
            for (int l = 0; l < 16; l++) begin
                e.lane = l;
                e.exp  = (w == 0) ? 64'h1111 : 64'h2222;
                e.port = 1'b0; sb.push_back(e);
                e.port = 1'b1; sb.push_back(e);
            end
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = e.port ? rd1[e.lane] : rd0[e.lane];
                tests_run++;
                if (act !== e.exp) begin
                    tests_failed++;
                    $display("FAIL warp_iso w%0d port%0d lane%0d got %h want %h",
                             w, e.port, e.lane, act, e.exp);
                end
            end
        end
    endtask

    task automatic test_read_en_low();
        sb_entry_t   e;
        logic [63:0] act;
        push_reads(4'd0, 4'd5, 4'd5, 16'hFFFF, 16'h0000);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL read_en_low port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
        // Mixed enables across lanes on both ports.
        push_reads(4'd1, 4'd5, 4'd5, 16'hA5C3, 16'h5A3C);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL read_en_mix port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
    endtask

    task automatic test_rw_same_cycle();
        sb_entry_t   e;
        logic [63:0] act;
        logic [63:0] d [16];
        logic [63:0] during;
`ifdef REGISTER_BLOCK_BYPASS_EN
        during = 64'h9;
`else
        during = 64'h5;
`endif
        for (int l = 0; l < 16; l++) d[l] = 64'h5;
        do_write(4'd4, 4'd7, 16'hFFFF, d);
        warp_selector = 4'd4;
        waddr         = 4'd7;
        raddr_0       = 4'd7;
        raddr_1       = 4'd7;
        read_en_0     = 16'hFFFF;
        read_en_1     = 16'hFFFF;
        for (int l = 0; l < 16; l++) wd[l] = 64'h9;
        write_en = 16'hFFFF;
        for (int l = 0; l < 16; l++) begin
            e.lane = l;
            e.exp  = during;
            e.port = 1'b0; sb.push_back(e);
            e.port = 1'b1; sb.push_back(e);
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL rw_during port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
        @(posedge clk);
        #1;
        write_en = '0;
        for (int l = 0; l < 16; l++) model[4][l][7] = 64'h9;
        for (int l = 0; l < 16; l++) begin
            e.lane = l;
            e.exp  = 64'h9;
            e.port = 1'b0; sb.push_back(e);
            e.port = 1'b1; sb.push_back(e);
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.port ? rd1[e.lane] : rd0[e.lane];
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL rw_after port%0d lane%0d got %h want %h", e.port, e.lane, act, e.exp);
            end
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        warp_selector = '0;
        read_en_0     = '0;
        read_en_1     = '0;
        raddr_0       = '0;
        raddr_1       = '0;
        write_en      = '0;
        waddr         = '0;
        for (int l = 0; l < 16; l++) wd[l] = '0;
        test_reset();
        test_sweep();
        test_lane_mask();
        test_warp_isolation();
        test_read_en_low();
        test_rw_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
